// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_arb_pkg
//  Purpose  : Shared definitions for the I2C request arbiter: FSM state
//             encoding and default sizing constants.
//  Ports    : (package, no ports)
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

  localparam int NREQ_DEFAULT        = 4;
  localparam int TIMEOUT_CYC_DEFAULT = 20000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_COMPLETE  = 3'd5
  } arb_state_e;

endpackage : i2c_arb_pkg
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin selector. Searches the request vector
//             starting one position after the last grant, wrapping at NREQ.
//  Ports    : req        in  NREQ  request levels
//             last_grant in  IDXW  index of the previously served requester
//             winner     out NREQ  one-hot winner (all-zero when no request)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] winner
);

  logic            found;
  logic [IDXW-1:0] sel;

  // Walk offsets 1..NREQ so the last-served requester is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sel = IDXW'((int'(last_grant) + k) % NREQ);
      if (!found && req[sel]) begin
        winner[sel] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_req_arbiter
//  Purpose  : Shares one i2c_master between NREQ requesters. Arbitrates
//             round-robin, launches the master, supervises the transaction
//             with a timeout and returns done/err pulses to the winner.
//  Ports    : clk100mhz in   clock
//             res       in   asynchronous active-high reset
//             req       in   NREQ   request levels
//             req_addr  in   8*NREQ address bytes (bit0 = rw)
//             req_data  in   8*NREQ write data bytes
//             gnt       out  NREQ   one-hot grant, held for the transaction
//             done      out  NREQ   completion pulse
//             err       out  NREQ   error pulse (NACK or timeout)
//             m_start   out  start pulse to master
//             m_addr    out  8      address to master
//             m_data    out  8      data to master
//             m_busy    in   master busy level
//             m_done    in   master end-of-transaction pulse
//             m_nack    in   master NACK flag (valid with m_done)
//             active    out  high whenever not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic              clk100mhz,
  input  logic              res,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              m_start,
  output logic [7:0]        m_addr,
  output logic [7:0]        m_data,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack,
  output logic              active
);

  localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              CNTW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYC - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [7:0]      m_addr_q, m_addr_d;
  logic [7:0]      m_data_q, m_data_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            errf_q, errf_d;

  logic [NREQ-1:0] winner;
  logic [IDXW-1:0] win_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_q),
    .winner     (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = IDXW'(i);
    end
  end

  always_ff @(posedge clk100mhz or posedge res) begin
    if (res) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      last_q   <= IDX_LAST;   // requester 0 gets first priority
      m_addr_q <= 8'h00;
      m_data_q <= 8'h00;
      cnt_q    <= '0;
      errf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
      cnt_q    <= cnt_d;
      errf_q   <= errf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    last_d   = last_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    cnt_d    = cnt_q;
    errf_d   = errf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_ARB;
      end

      ST_ARB: begin
        // Requests may vanish between IDLE and ARB; then nothing is granted.
        if (|req) begin
          gnt_d = winner;
          idx_d = win_idx;
          for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
              m_addr_d = req_addr[8*i +: 8];
              m_data_d = req_data[8*i +: 8];
            end
          end
          state_d = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LAUNCH: begin
        cnt_d   = '0;
        errf_d  = 1'b0;
        state_d = ST_WAIT_BUSY;
      end

      // m_done is checked ahead of the timeout so a coincident completion
      // reports only the master's NACK status.
      ST_WAIT_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (m_done) begin
          errf_d  = m_nack;
          state_d = ST_COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          errf_d  = 1'b1;
          state_d = ST_COMPLETE;
        end else if (m_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (m_done) begin
          errf_d  = m_nack;
          state_d = ST_COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          errf_d  = 1'b1;
          state_d = ST_COMPLETE;
        end
      end

      ST_COMPLETE: begin
        last_d  = idx_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign m_addr  = m_addr_q;
  assign m_data  = m_data_q;
  assign m_start = (state_q == ST_LAUNCH);
  assign active  = (state_q != ST_IDLE);
  // gnt is still held during COMPLETE, so it steers the pulses.
  assign done    = (state_q == ST_COMPLETE) ? gnt_q : '0;
  assign err     = ((state_q == ST_COMPLETE) && errf_q) ? gnt_q : '0;

endmodule : i2c_req_arbiter
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_req_arbiter
//  Purpose  : Directed self-checking bench for i2c_req_arbiter with a small
//             hand-driven i2c_master model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

  localparam int NREQ = 4;
  localparam int TCYC = 16;

  logic              clk100mhz = 1'b0;
  logic              res;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt, done, err;
  logic              m_start, m_busy, m_done, m_nack, active;
  logic [7:0]        m_addr, m_data;

  int checks   = 0;
  int failures = 0;

  i2c_req_arbiter #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk100mhz (clk100mhz),
    .res       (res),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_nack    (m_nack),
    .active    (active)
  );

  always #5 clk100mhz = ~clk100mhz;

  task automatic step;
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic do_reset;
    res = 1'b1; req = '0; m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0;
    step; step;
    res = 1'b0;
    step;
  endtask

  // Waits (bounded) for m_start, then plays an acking master:
  // busy for two cycles, then a done pulse carrying nack.
  // Returns at the COMPLETE cycle; wait_cyc = -1 if m_start never came.
  task automatic do_txn(input logic nack, input logic drop_req,
                        output int wait_cyc, output logic [3:0] g,
                        output logic [7:0] a, output logic [7:0] d,
                        output logic [3:0] dn, output logic [3:0] er);
    wait_cyc = 0; g = '0; a = '0; d = '0; dn = '0; er = '0;
    while (m_start !== 1'b1 && wait_cyc < 10) begin
      step;
      wait_cyc++;
    end
    if (m_start !== 1'b1) begin
      wait_cyc = -1;
    end else begin
      g = gnt; a = m_addr; d = m_data;
      if (drop_req) req = '0;
      m_busy = 1'b1;
      step; step;
      m_done = 1'b1; m_nack = nack;
      step;
      dn = done; er = err;
      m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0;
    end
  endtask

  task automatic test_reset;
    res = 1'b1; req = 4'hF; m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_data = 32'hFFFF_FFFF;
    step; step;
    checks++;
    if ({gnt, done, err, m_start, active} !== 14'h0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=0", {gnt, done, err, m_start, active});
    end
    checks++;
    if ({m_addr, m_data} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0000", {m_addr, m_data});
    end
    res = 1'b0; req = '0;
    step;
  endtask

  task automatic test_single;
    int w; logic [3:0] g, dn, er; logic [7:0] a, d;
    do_reset;
    req_addr = '0; req_data = '0;
    req_addr[7:0] = 8'h98; req_data[7:0] = 8'h55;
    req = 4'b0001;
    step;
    checks++;
    if ({active, m_start} !== 2'b10) begin
      failures++;
      $display("FAIL single_arb_cycle got=%b exp=10", {active, m_start});
    end
    do_txn(1'b0, 1'b0, w, g, a, d, dn, er);
    checks++;
    if (w !== 1) begin failures++; $display("FAIL single_start_lat got=%0d exp=1", w); end
    checks++;
    if ({g, a, d} !== {4'b0001, 8'h98, 8'h55}) begin
      failures++;
      $display("FAIL single_launch got=%h exp=%h", {g, a, d}, {4'b0001, 8'h98, 8'h55});
    end
    checks++;
    if ({dn, er} !== 8'b0001_0000) begin
      failures++;
      $display("FAIL single_done got=%b exp=00010000", {dn, er});
    end
    req = '0;
    step;
    checks++;
    if ({active, done, m_addr, m_data} !== {1'b0, 4'b0, 8'h98, 8'h55}) begin
      failures++;
      $display("FAIL single_idle_stable got=%h exp=%h", {active, done, m_addr, m_data},
               {1'b0, 4'b0, 8'h98, 8'h55});
    end
  endtask

  task automatic test_round_robin;
    int w; logic [3:0] g, dn, er, eg; logic [7:0] a, d;
    int e;
    do_reset;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[8*i +: 8] = 8'h10 + 8'(2*i);
      req_data[8*i +: 8] = 8'hA0 + 8'(i);
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      e  = n % 4;
      eg = 4'(1 << e);
      do_txn(1'b0, 1'b0, w, g, a, d, dn, er);
      checks++;
      if ({g, a, d, dn, er} !== {eg, 8'h10 + 8'(2*e), 8'hA0 + 8'(e), eg, 4'b0}) begin
        failures++;
        $display("FAIL rr_txn%0d got=%h exp=%h", n, {g, a, d, dn, er},
                 {eg, 8'h10 + 8'(2*e), 8'hA0 + 8'(e), eg, 4'b0});
      end
      checks++;
      if (w !== ((n == 0) ? 2 : 3)) begin
        failures++;
        $display("FAIL rr_gap%0d got=%0d exp=%0d", n, w, (n == 0) ? 2 : 3);
      end
    end
    req = '0;
    step; step;
  endtask

  task automatic test_lone;
    int w; logic [3:0] g, dn, er; logic [7:0] a, d;
    do_reset;
    req = 4'b0100;
    for (int n = 0; n < 2; n++) begin
      do_txn(1'b0, 1'b0, w, g, a, d, dn, er);
      checks++;
      if ({g, dn} !== 8'b0100_0100) begin
        failures++;
        $display("FAIL lone%0d got=%b exp=01000100", n, {g, dn});
      end
    end
    req = '0;
    step; step;
  endtask

  task automatic test_drops;
    int w; logic [3:0] g, dn, er; logic [7:0] a, d;
    // Request withdrawn after launch: transaction still completes.
    do_reset;
    req = 4'b1000;
    do_txn(1'b0, 1'b1, w, g, a, d, dn, er);
    checks++;
    if ({g, dn, er} !== 12'b1000_1000_0000) begin
      failures++;
      $display("FAIL drop_after_grant got=%b exp=100010000000", {g, dn, er});
    end
    step; step;
    // Request withdrawn during ARB: back to IDLE with no grant.
    do_reset;
    req = 4'b0010;
    step;
    req = '0;
    step;
    checks++;
    if ({active, gnt, m_start} !== 6'b0) begin
      failures++;
      $display("FAIL arb_abort got=%b exp=000000", {active, gnt, m_start});
    end
    step; step;
    checks++;
    if ({active, m_start} !== 2'b0) begin
      failures++;
      $display("FAIL arb_abort_stay got=%b exp=00", {active, m_start});
    end
  endtask

  task automatic test_nack;
    int w; logic [3:0] g, dn, er; logic [7:0] a, d;
    do_reset;
    req = 4'b0010;
    do_txn(1'b1, 1'b0, w, g, a, d, dn, er);
    checks++;
    if ({g, dn, er} !== 12'b0010_0010_0010) begin
      failures++;
      $display("FAIL nack got=%b exp=001000100010", {g, dn, er});
    end
    req = '0;
    step; step;
  endtask

  task automatic test_timeout;
    int k;
    do_reset;
    req = 4'b0001;
    k = 0;
    while (m_start !== 1'b1 && k < 10) begin step; k++; end
    checks++;
    if (m_start !== 1'b1) begin
      failures++;
      $display("FAIL timeout_launch got=%b exp=1", m_start);
    end
    req = '0;
    k = 0;
    while (done === 4'b0 && k < TCYC + 10) begin step; k++; end
    checks++;
    if (k !== TCYC + 1) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=%0d", k, TCYC + 1);
    end
    checks++;
    if ({done, err} !== 8'b0001_0001) begin
      failures++;
      $display("FAIL timeout_err got=%b exp=00010001", {done, err});
    end
    step;
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle got=%b exp=0", active);
    end
  endtask

  task automatic test_timeout_tie;
    int k;
    do_reset;
    req = 4'b0001;
    k = 0;
    while (m_start !== 1'b1 && k < 10) begin step; k++; end
    req = '0;
    m_busy = 1'b1;
    for (int n = 0; n < TCYC; n++) step;
    checks++;
    if ({active, done} !== 5'b1_0000) begin
      failures++;
      $display("FAIL tie_pre got=%b exp=10000", {active, done});
    end
    m_done = 1'b1; m_nack = 1'b0;
    step;
    checks++;
    if ({done, err} !== 8'b0001_0000) begin
      failures++;
      $display("FAIL tie_done got=%b exp=00010000", {done, err});
    end
    m_busy = 1'b0; m_done = 1'b0;
    step;
  endtask

  task automatic test_reset_mid;
    int w, k; logic [3:0] g, dn, er, seen; logic [7:0] a, d;
    do_reset;
    req_addr[23:16] = 8'h77; req_data[23:16] = 8'h66;
    req = 4'b0100;
    k = 0;
    while (m_start !== 1'b1 && k < 10) begin step; k++; end
    m_busy = 1'b1;
    step; step;
    checks++;
    if ({active, gnt} !== 5'b1_0100) begin
      failures++;
      $display("FAIL mid_pre got=%b exp=10100", {active, gnt});
    end
    res = 1'b1;
    #1;
    checks++;
    if ({gnt, done, err, m_start, active, m_addr, m_data} !== 30'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0",
               {gnt, done, err, m_start, active, m_addr, m_data});
    end
    m_busy = 1'b0; req = '0;
    step;
    res = 1'b0;
    seen = '0;
    for (int n = 0; n < 5; n++) begin
      step;
      seen = seen | done | err;
    end
    checks++;
    if (seen !== 4'b0) begin
      failures++;
      $display("FAIL mid_no_pulse got=%b exp=0000", seen);
    end
    req = 4'b0101;
    do_txn(1'b0, 1'b0, w, g, a, d, dn, er);
    checks++;
    if ({g, dn} !== 8'b0001_0001) begin
      failures++;
      $display("FAIL mid_first_grant got=%b exp=00010001", {g, dn});
    end
    req = '0;
    step; step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_lone;
    test_drops;
    test_nack;
    test_timeout;
    test_timeout_tie;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_i2c_req_arbiter
`default_nettype wire

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one i2c_master.
REQ-002 Parameter TIMEOUT_CYC, default 20000: clk100mhz cycles allowed per transaction before it is aborted with an error.
REQ-003 clk100mhz  in  1  sole clock.
REQ-004 res  in  1  reset, asynchronous, active-high.
REQ-005 req  in  NREQ  per-requester transaction request level.
REQ-006 req_addr  in  8*NREQ  per-requester address byte; bit0 is rw (1 = read).
REQ-007 req_data  in  8*NREQ  per-requester write data byte.
REQ-008 gnt  out  NREQ  one-hot grant, held for the whole transaction.
REQ-009 done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 err  out  NREQ  one-cycle error pulse (NACK or timeout), coincident with done.
REQ-011 m_start  out  1  one-cycle start pulse to the i2c_master.
REQ-012 m_addr  out  8  registered addr_to_send to the master.
REQ-013 m_data  out  8  registered data_to_send to the master.
REQ-014 m_busy  in  1  master transaction-in-progress level.
REQ-015 m_done  in  1  master one-cycle end-of-transaction pulse.
REQ-016 m_nack  in  1  master NACK flag, valid only while m_done is high.
REQ-017 active  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE.
REQ-019 IDLE -> ARB when any req bit is high; otherwise stay in IDLE.
REQ-020 ARB (1 cycle) performs round-robin selection starting at index (last_grant+1) mod NREQ.
REQ-021 ARB registers gnt, m_addr and m_data from the winner, then goes to LAUNCH.
REQ-022 If req drops to all-zero during ARB, the FSM returns to IDLE with no grant.
REQ-023 LAUNCH (1 cycle) drives m_start=1, then goes to WAIT_BUSY.
REQ-024 m_start is asserted in the second cycle after req is first sampled high in IDLE.
REQ-025 WAIT_BUSY -> WAIT_DONE on m_busy=1.
REQ-026 WAIT_BUSY -> COMPLETE directly if m_done=1 arrives first.
REQ-027 WAIT_DONE -> COMPLETE on m_done=1, capturing m_nack into the error flag.
REQ-028 Timeout counter clears in LAUNCH and increments in WAIT_BUSY and WAIT_DONE.
REQ-029 At count TIMEOUT_CYC-1 the FSM goes to COMPLETE with the error flag set.
REQ-030 If m_done and timeout expiry occur in the same cycle, m_done wins and err reflects m_nack only.
REQ-031 COMPLETE (1 cycle) pulses done[g], and err[g] if the error flag is set.
REQ-032 COMPLETE updates last_grant to g, clears gnt and returns to IDLE.
REQ-033 Back-to-back requests therefore have a minimum 1-cycle IDLE gap.
REQ-034 Requests are sampled only in ARB; a deasserted req after grant does not abort the transaction.
REQ-035 m_addr and m_data stay stable from ARB until the next ARB.
REQ-036 Round-robin wraps from index NREQ-1 to index 0.
REQ-037 A lone requester is granted on every arbitration.

Reset
REQ-038 On res=1: state=IDLE; gnt, done, err, m_start, active = 0; m_addr = m_data = 8'h00; counter = 0; last_grant = NREQ-1, so requester 0 has first priority.
REQ-039 Reset asserted mid-transaction abandons it immediately; no done or err pulse is issued.

Structure
REQ-040 Shared package i2c_arb_pkg holds the FSM state enum and the default NREQ and TIMEOUT_CYC constants.
REQ-041 Round-robin selection is a combinational sub-module, rr_pick (inputs req and last_grant; output one-hot winner).

Verification
REQ-042 req=4'b0001, addr 8'h98, data 8'h55; model acks -> m_start on 2nd cycle, m_addr=8'h98, m_data=8'h55, done[0] pulses, err=0.
REQ-043 req=4'b1111 held, 4 transactions -> grant order 0,1,2,3, then 0 again.
REQ-044 Model returns m_nack=1 with m_done -> done[g] and err[g] pulse in the same cycle.
REQ-045 Model never raises m_busy -> err[g] pulses TIMEOUT_CYC+1 cycles after m_start, FSM returns to IDLE.
REQ-046 res asserted during WAIT_DONE -> all outputs zero within the same cycle, no done/err; next req is granted to index 0 first.
REQ-047 m_done coincident with timeout expiry, m_nack=0 -> done pulses, err stays 0.
